// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// forward-select codes and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: register indices and enables in,
// stall/flush/forward controls out. The controller uses the slave modport.
interface hazard_ctrl_if #(
  parameter int REG_W = 5
) ();

  logic [REG_W-1:0] rsD, rtD, rsE, rtE;
  logic [REG_W-1:0] write_regE, write_regM, write_regW;
  logic             regwriteE, regwriteM, regwriteW;
  logic             memtoregE, memtoregM;
  logic             branchD, pcsrcD;
  logic             dm_reqM, dm_ready;

  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, bubbleW;
  logic [1:0]       forwardAE, forwardBE;
  logic             forwardAD, forwardBD;
  logic             mem_wait, mem_err;

  modport slave (
    input  rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, pcsrcD, dm_reqM, dm_ready,
    output stallF, stallD, stallE, stallM, flushD, flushE, bubbleW,
           forwardAE, forwardBE, forwardAD, forwardBD, mem_wait, mem_err
  );

  modport master (
    output rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, pcsrcD, dm_reqM, dm_ready,
    input  stallF, stallD, stallE, stallM, flushD, flushE, bubbleW,
           forwardAE, forwardBE, forwardAD, forwardBD, mem_wait, mem_err
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational forwarding selects for the EX operands (M over W priority)
// and the ID branch-compare operands (M only).
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_e_i,
  input  logic [REG_W-1:0] rt_e_i,
  input  logic [REG_W-1:0] rs_d_i,
  input  logic [REG_W-1:0] rt_d_i,
  input  logic [REG_W-1:0] wr_m_i,
  input  logic [REG_W-1:0] wr_w_i,
  input  logic             regwrite_m_i,
  input  logic             regwrite_w_i,
  output logic [1:0]       fwd_ae_o,
  output logic [1:0]       fwd_be_o,
  output logic             fwd_ad_o,
  output logic             fwd_bd_o
);

  localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

  // Register 0 is hard-wired, so a write to it never produces a forward.
  function automatic logic hit(input logic [REG_W-1:0] src,
                               input logic             en,
                               input logic [REG_W-1:0] dst);
    return (src != ZERO) && en && (dst == src);
  endfunction

  function automatic logic [1:0] ex_sel(input logic [REG_W-1:0] src,
                                        input logic             en_m,
                                        input logic [REG_W-1:0] dst_m,
                                        input logic             en_w,
                                        input logic [REG_W-1:0] dst_w);
    if (hit(src, en_m, dst_m)) return FWD_M;
    if (hit(src, en_w, dst_w)) return FWD_W;
    return FWD_RF;
  endfunction

  assign fwd_ae_o = ex_sel(rs_e_i, regwrite_m_i, wr_m_i, regwrite_w_i, wr_w_i);
  assign fwd_be_o = ex_sel(rt_e_i, regwrite_m_i, wr_m_i, regwrite_w_i, wr_w_i);
  assign fwd_ad_o = hit(rs_d_i, regwrite_m_i, wr_m_i);
  assign fwd_bd_o = hit(rt_d_i, regwrite_m_i, wr_m_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush/bubble, forwarding and
// a memory-wait FSM with timeout. HAZARD_PERF_CNT_EN adds stall-cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lw,
  output logic [31:0] perf_br,
  output logic [31:0] perf_mem
`endif
);

  localparam logic [REG_W-1:0] ZERO    = REG_W'(REG_ZERO);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);

  hz_state_e        state_q;
  logic [TMO_W-1:0] cnt_q;
  logic             mem_wait_q, mem_err_q;

  logic lw_stall, br_stall, mem_stall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, bubble_w;

  fwd_unit #(.REG_W(REG_W)) u_fwd (
    .rs_e_i       (hz.rsE),
    .rt_e_i       (hz.rtE),
    .rs_d_i       (hz.rsD),
    .rt_d_i       (hz.rtD),
    .wr_m_i       (hz.write_regM),
    .wr_w_i       (hz.write_regW),
    .regwrite_m_i (hz.regwriteM),
    .regwrite_w_i (hz.regwriteW),
    .fwd_ae_o     (hz.forwardAE),
    .fwd_be_o     (hz.forwardBE),
    .fwd_ad_o     (hz.forwardAD),
    .fwd_bd_o     (hz.forwardBD)
  );

  assign lw_stall = hz.memtoregE && (hz.write_regE != ZERO) &&
                    ((hz.rsD == hz.write_regE) || (hz.rtD == hz.write_regE));

  assign br_stall = hz.branchD &&
    ((hz.regwriteE && (hz.write_regE != ZERO) &&
      ((hz.write_regE == hz.rsD) || (hz.write_regE == hz.rtD))) ||
     (hz.memtoregM && (hz.write_regM != ZERO) &&
      ((hz.write_regM == hz.rsD) || (hz.write_regM == hz.rtD))));

  assign mem_stall = (hz.dm_reqM && !hz.dm_ready) || (state_q == ERR);

  // A memory stall freezes everything, so no flush may discard held stages.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_w = 1'b0;
    if (mem_stall) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      bubble_w = 1'b1;
    end else if (lw_stall || br_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      flush_d = hz.pcsrcD;
    end
  end

  assign hz.stallF   = stall_f;
  assign hz.stallD   = stall_d;
  assign hz.stallE   = stall_e;
  assign hz.stallM   = stall_m;
  assign hz.flushD   = flush_d;
  assign hz.flushE   = flush_e;
  assign hz.bubbleW  = bubble_w;
  assign hz.mem_wait = mem_wait_q;
  assign hz.mem_err  = mem_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_wait_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz.dm_reqM && !hz.dm_ready) begin
            state_q    <= WAIT;
            cnt_q      <= CNT_ONE;
            mem_wait_q <= 1'b1;
          end
        end
        WAIT: begin
          // A withdrawn request ends the wait just like a completed one.
          if (!hz.dm_reqM || hz.dm_ready) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_wait_q <= 1'b0;
          end else if (cnt_q == TMO_LIM) begin
            state_q    <= ERR;
            mem_wait_q <= 1'b0;
            mem_err_q  <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          mem_wait_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lw_q, perf_lw_d;
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Each cycle is charged to the single stall cause that wins priority.
  always_comb begin
    perf_lw_d  = perf_lw_q;
    perf_br_d  = perf_br_q;
    perf_mem_d = perf_mem_q;
    if (mem_stall)     perf_mem_d = sat_inc32(perf_mem_q);
    else if (lw_stall) perf_lw_d  = sat_inc32(perf_lw_q);
    else if (br_stall) perf_br_d  = sat_inc32(perf_br_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_lw_q  <= '0;
      perf_br_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      perf_lw_q  <= perf_lw_d;
      perf_br_q  <= perf_br_d;
      perf_mem_q <= perf_mem_d;
    end
  end

  assign perf_lw  = perf_lw_q;
  assign perf_br  = perf_br_q;
  assign perf_mem = perf_mem_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl with a queue scoreboard; MEM_TIMEOUT is
// shortened to 4 so the watchdog path is reachable in a few cycles.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(5)) hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lw, perf_br, perf_mem;
`endif

  hazard_ctrl #(
    .REG_W       (5),
    .TMO_W       (8),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_lw  (perf_lw),
    .perf_br  (perf_br),
    .perf_mem (perf_mem)
`endif
  );

  // ctl bits: [9] reset_n [8] regwriteE [7] regwriteM [6] regwriteW
  //           [5] memtoregE [4] memtoregM [3] branchD [2] pcsrcD [1] dm_reqM [0] dm_ready
  // exp bits: stallF,D,E,M | flushD,flushE,bubbleW | fwdAE | fwdBE | fwdAD,fwdBD | mem_wait,mem_err
  typedef struct {
    string       name;
    logic [4:0]  rsD, rtD, rsE, rtE, wE, wM, wW;
    logic [9:0]  ctl;
    logic [14:0] exp;
  } vec_t;

  localparam logic [14:0] S  = {4'b1111, 3'b001, 8'b0};
  localparam logic [14:0] MW = 15'b000_0000_0000_0010;
  localparam logic [14:0] ME = 15'b000_0000_0000_0001;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string n, logic [4:0] rsD, logic [4:0] rtD,
                              logic [4:0] rsE, logic [4:0] rtE, logic [4:0] wE,
                              logic [4:0] wM, logic [4:0] wW,
                              logic [9:0] ctl, logic [14:0] exp);
    vec_t v;
    v.name = n; v.rsD = rsD; v.rtD = rtD; v.rsE = rsE; v.rtE = rtE;
    v.wE = wE; v.wM = wM; v.wW = wW; v.ctl = ctl; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hif.rsD = v.rsD; hif.rtD = v.rtD; hif.rsE = v.rsE; hif.rtE = v.rtE;
    hif.write_regE = v.wE; hif.write_regM = v.wM; hif.write_regW = v.wW;
    reset         = v.ctl[9];
    hif.regwriteE = v.ctl[8];
    hif.regwriteM = v.ctl[7];
    hif.regwriteW = v.ctl[6];
    hif.memtoregE = v.ctl[5];
    hif.memtoregM = v.ctl[4];
    hif.branchD   = v.ctl[3];
    hif.pcsrcD    = v.ctl[2];
    hif.dm_reqM   = v.ctl[1];
    hif.dm_ready  = v.ctl[0];
    sb.push_back(v);
  endtask

  task automatic check_one();
    vec_t        e;
    logic [14:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries, required 1");
      return;
    end
    e   = sb.pop_front();
    obs = {hif.stallF, hif.stallD, hif.stallE, hif.stallM,
           hif.flushD, hif.flushE, hif.bubbleW,
           hif.forwardAE, hif.forwardBE, hif.forwardAD, hif.forwardBD,
           hif.mem_wait, hif.mem_err};
    if (obs !== e.exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", e.name, obs, e.exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    apply(v);
    @(negedge clk);
    check_one();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
    hif.write_regE = '0; hif.write_regM = '0; hif.write_regW = '0;
    hif.regwriteE = 0; hif.regwriteM = 0; hif.regwriteW = 0;
    hif.memtoregE = 0; hif.memtoregM = 0; hif.branchD = 0; hif.pcsrcD = 0;
    hif.dm_reqM = 0; hif.dm_ready = 0;
    repeat (2) @(posedge clk);

    tbl.push_back(mk("reset_state",  0,0,0,0,0,0,0, 10'b0000000000, 15'b0));
    tbl.push_back(mk("fwd_m_over_w", 0,0,8,0,0,8,8, 10'b1011000000, {4'b0,3'b0,2'b10,2'b00,4'b0000}));
    tbl.push_back(mk("fwd_rs_zero",  0,0,0,0,0,8,8, 10'b1011000000, 15'b0));
    tbl.push_back(mk("fwd_w_b",      0,0,0,3,0,0,3, 10'b1001000000, {4'b0,3'b0,2'b00,2'b01,4'b0000}));
    tbl.push_back(mk("fwd_w_no_m",   0,0,3,3,0,3,3, 10'b1001000000, {4'b0,3'b0,2'b01,2'b01,4'b0000}));
    tbl.push_back(mk("fwd_id",       6,6,0,0,0,6,0, 10'b1010000000, {4'b0,3'b0,2'b00,2'b00,4'b1100}));
    tbl.push_back(mk("lw_stall",     0,9,0,0,9,0,0, 10'b1100100000, {4'b1100,3'b010,8'b0}));
    tbl.push_back(mk("lw_release",   0,9,0,0,9,0,0, 10'b1100000000, 15'b0));
    tbl.push_back(mk("br_stall",     4,0,0,0,4,0,0, 10'b1100001100, {4'b1100,3'b010,8'b0}));
    tbl.push_back(mk("br_taken",     4,0,0,0,4,0,0, 10'b1000001100, {4'b0000,3'b100,8'b0}));
    tbl.push_back(mk("br_memtoregM", 0,5,0,0,0,5,0, 10'b1010011000, {4'b1100,3'b010,2'b00,2'b00,4'b0100}));
    tbl.push_back(mk("req_ready",    0,0,0,0,0,0,0, 10'b1000000111, {4'b0000,3'b100,8'b0}));
    tbl.push_back(mk("mem_priority", 0,9,0,0,9,0,0, 10'b1100100110, S));
    tbl.push_back(mk("mem_wait_1",   0,0,0,0,0,0,0, 10'b1000000010, S | MW));
    tbl.push_back(mk("mem_wait_2",   0,0,0,0,0,0,0, 10'b1000000010, S | MW));
    tbl.push_back(mk("mem_ready",    0,0,0,0,0,0,0, 10'b1000000011, MW));
    tbl.push_back(mk("mem_idle",     0,0,0,0,0,0,0, 10'b1000000000, 15'b0));
    tbl.push_back(mk("wd_first",     0,0,0,0,0,0,0, 10'b1000000010, S));
    tbl.push_back(mk("wd_withdraw",  0,0,0,0,0,0,0, 10'b1000000000, MW));
    tbl.push_back(mk("wd_idle",      0,0,0,0,0,0,0, 10'b1000000000, 15'b0));

    foreach (tbl[i]) step(tbl[i]);

    // Timeout: one IDLE stall cycle, four WAIT cycles, then sticky ERR.
    step(mk("tmo_first", 0,0,0,0,0,0,0, 10'b1000000010, S));
    for (int i = 0; i < 4; i++)
      step(mk("tmo_wait", 0,0,0,0,0,0,0, 10'b1000000010, S | MW));
    step(mk("tmo_err",      0,0,0,0,0,0,0, 10'b1000000010, S | ME));
    step(mk("tmo_err_hold", 0,0,0,0,0,0,0, 10'b1000000000, S | ME));
    step(mk("tmo_reset",    0,0,0,0,0,0,0, 10'b0000000000, S | ME));
    step(mk("tmo_cleared",  0,0,0,0,0,0,0, 10'b1000000000, 15'b0));

    // Reset in WAIT with cnt = 2; a full timeout afterwards proves cnt restarted.
    step(mk("rmw_first",  0,0,0,0,0,0,0, 10'b1000000010, S));
    step(mk("rmw_cnt1",   0,0,0,0,0,0,0, 10'b1000000010, S | MW));
    step(mk("rmw_reset",  0,0,0,0,0,0,0, 10'b0000000010, S | MW));
    step(mk("rmw_idle",   0,0,0,0,0,0,0, 10'b1000000010, S));
    for (int i = 0; i < 4; i++)
      step(mk("rmw_rewait", 0,0,0,0,0,0,0, 10'b1000000010, S | MW));
    step(mk("rmw_err",    0,0,0,0,0,0,0, 10'b1000000010, S | ME));
    step(mk("rmw_reset2", 0,0,0,0,0,0,0, 10'b0000000000, S | ME));
    step(mk("rmw_clean",  0,0,0,0,0,0,0, 10'b1000000000, 15'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the five-stage MIPS pipeline.
- Drives the stall, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates the forwarding selects for the EX and ID stages.
- Runs a small FSM that stalls the whole pipeline while the data memory is not ready, with a timeout watchdog.

Parameters:
- REG_W, 5, register-index width.
- TMO_W, 8, width of the memory-wait cycle counter.
- MEM_TIMEOUT, 200, number of consecutive wait cycles after which the controller enters ERR (must be < 2^TMO_W).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge
- rsD, rtD  in  REG_W  source registers in ID
- rsE, rtE  in  REG_W  source registers in EX
- write_regE, write_regM, write_regW  in  REG_W  destination registers
- regwriteE, regwriteM, regwriteW  in  1  register-write enables per stage
- memtoregE, memtoregM  in  1  load in EX / MEM
- branchD  in  1  branch in ID (compare in ID)
- pcsrcD  in  1  branch taken / jump resolved in ID
- dm_reqM  in  1  load/store in MEM
- dm_ready  in  1  data memory ready; the access completes in the cycle it is high
- stallF, stallD, stallE, stallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers
- flushD, flushE  out  1  clear IF/ID and ID/EX (bubble)
- bubbleW  out  1  force the MEM/WB regwrite and memtoreg inputs to 0
- forwardAE, forwardBE  out  2  00 = register file, 10 = alu_outM, 01 = result W
- forwardAD, forwardBD  out  1  ID compare operand from alu_outM
- mem_wait  out  1  FSM in WAIT
- mem_err  out  1  sticky timeout flag

Behaviour:
- Forwarding is combinational.
  - forwardAE = 10 if rsE != 0 & regwriteM & write_regM == rsE; else 01 if rsE != 0 & regwriteW & write_regW == rsE; else 00. M has priority over W.
  - forwardBE is the same function of rtE.
  - forwardAD = rsD != 0 & regwriteM & write_regM == rsD. forwardBD is the same function of rtD.
- Load-use stall: lwstall = memtoregE & (rsD == write_regE | rtD == write_regE) & write_regE != 0.
- Branch stall: brstall = branchD & ((regwriteE & write_regE ∈ {rsD, rtD}) | (memtoregM & write_regM ∈ {rsD, rtD})), with nonzero destination.
- memstall = (dm_reqM & ~dm_ready) | state == ERR.
- Priority is memstall > lwstall/brstall > pcsrcD.
  - memstall: stallF = stallD = stallE = stallM = 1, bubbleW = 1, flushD = flushE = 0.
  - Otherwise lw/br stall: stallF = stallD = 1, flushE = 1, stallE = stallM = 0, bubbleW = 0.
  - Otherwise flushD = pcsrcD.
  - flushD is never asserted while stallD = 1.
- FSM states:
  - IDLE -> WAIT when dm_reqM & ~dm_ready; cnt <= 1.
  - WAIT stays while ~dm_ready, cnt++. -> IDLE when dm_ready (stall drops the same cycle; the access is captured). -> ERR when cnt == MEM_TIMEOUT & ~dm_ready.
  - ERR is terminal until reset; mem_err = 1 and the whole pipeline stays stalled.
  - dm_ready together with dm_reqM in IDLE means no stall and no state change.
  - dm_reqM dropping while in WAIT -> IDLE (request withdrawn, e.g. after reset of upstream).
  - cnt saturates and never wraps.
- Reset (reset = 0 at a clk edge):
  - state = IDLE, cnt = 0, mem_err = 0, mem_wait = 0.
  - The combinational outputs follow their inputs; the next cycle is IDLE regardless of a pending access.
- Latency: all stall, flush and forward outputs are combinational, with zero-cycle latency from inputs and state.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_lw[31:0], perf_br[31:0] and perf_mem[31:0], counting cycles with lwstall, brstall and memstall (in winning-priority order, one counter per cycle).
  - The counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, ERR = 2'd2).
  - Forward-select constants FWD_RF, FWD_M and FWD_W.
  - REG_ZERO = 5'd0.
- Sub-module fwd_unit holds the purely combinational forwarding logic for the EX and ID selects.
- The FSM, stall logic and counters stay in hazard_ctrl.

Test Plan:
- Forwarding priority: regwriteM = 1, write_regM = 8, regwriteW = 1, write_regW = 8, rsE = 8 -> forwardAE = 10. With rsE = 0 and the same writes -> forwardAE = 00.
- Load-use: memtoregE = 1, write_regE = 9, rtD = 9 for one cycle -> stallF = stallD = flushE = 1, stallE = 0, then release the next cycle when memtoregE = 0.
- Branch hazard: branchD = 1, rsD = 4, regwriteE = 1, write_regE = 4, pcsrcD = 1 -> stallD = 1, flushE = 1, flushD = 0. Next cycle with no hazard -> flushD = 1.
- Memory wait: dm_reqM = 1, dm_ready = 0 for 3 cycles, then 1 -> mem_wait high for cycles 2–4, all stalls and bubbleW = 1 for 3 cycles, released in the dm_ready cycle, FSM back to IDLE.
- Timeout: MEM_TIMEOUT = 4, dm_ready held 0 -> mem_err = 1 after 4 WAIT cycles, stalls persist. Then reset = 0 for one edge -> mem_err = 0, state IDLE.
- Reset mid-wait: assert reset while in WAIT with cnt = 2 -> the next cycle is IDLE with cnt = 0. With dm_reqM = 1 and dm_ready = 0 still present, WAIT is re-entered one cycle later.
